// File: rtl/vec_alu_pipe.sv
// Two-stage LANES x WIDTH SIMD ALU with operand-B select,
// per-lane write-merge mask and valid/ready backpressure.
module vec_alu_pipe #(
  parameter int LANES = 6,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] src_a,
  input  logic [LANES*WIDTH-1:0] src_b,
  input  logic [IDXW-1:0]        b_idx,
  input  logic [WIDTH-1:0]       imm,
  input  logic [1:0]             b_sel,
  input  logic [2:0]             alu_ctrl,
  input  logic [LANES-1:0]       lane_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES*2-1:0]     flags
);

  localparam int VW  = LANES * WIDTH;
  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [VW-1:0]    a;
    logic [VW-1:0]    b;
    logic [2:0]       op;
    logic [LANES-1:0] mask;
  } s1_t;

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s1_valid;
  logic             s2_adv;
  logic             s1_adv;
  logic             acc;
  logic [WIDTH-1:0] bcast;
  logic [VW-1:0]    b_vec;
  logic [WIDTH:0]   lane;
  logic [VW-1:0]    nres;
  logic [2*LANES-1:0] nflg;

  // Returns {carry, result} for one lane.
  function automatic logic [WIDTH:0] alu_lane(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]     wide;
    logic [WIDTH:0]     tmp;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     sh;
    sh   = b[SHW-1:0];
    wide = '0;
    tmp  = '0;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    unique case (op)
      3'b000: wide = {1'b0, a} + {1'b0, b};
      3'b001: begin
        wide = {1'b0, a} - {1'b0, b};
        wide[WIDTH] = ~wide[WIDTH];
      end
      3'b010: wide = {1'b0, a & b};
      3'b011: wide = {1'b0, a | b};
      3'b100: wide = {1'b0, a ^ b};
      3'b101: wide = {1'b0, a} << sh;
      3'b110: begin
        // Bit 0 catches the last bit shifted out.
        tmp  = {a, 1'b0} >> sh;
        wide = {tmp[0], tmp[WIDTH:1]};
      end
      default: wide = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
    endcase
    return wide;
  endfunction

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign acc      = in_valid && in_ready;

  always_comb begin
    bcast = src_b[0 +: WIDTH];
    for (int i = 0; i < LANES; i++) begin
      if (b_idx == IDXW'(i)) bcast = src_b[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    b_vec = src_b;
    case (b_sel)
      2'b01:   b_vec = {LANES{bcast}};
      2'b10:   b_vec = {LANES{imm}};
      default: b_vec = src_b;
    endcase
  end

  always_comb begin
    s1_d.a    = src_a;
    s1_d.b    = b_vec;
    s1_d.op   = alu_ctrl;
    s1_d.mask = lane_mask;
  end

  always_comb begin
    nres = result;
    nflg = flags;
    lane = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = alu_lane(s1_q.op,
                      s1_q.a[i*WIDTH +: WIDTH],
                      s1_q.b[i*WIDTH +: WIDTH]);
      if (s1_q.mask[i]) begin
        nres[i*WIDTH +: WIDTH] = lane[WIDTH-1:0];
        nflg[2*i +: 2] = {lane[WIDTH-1:0] == '0,
                          lane[WIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (acc)      s1_q     <= s1_d;
      if (s2_adv)   out_valid <= s1_valid;
      if (s1_adv) begin
        result <= nres;
        flags  <= nflg;
      end
    end
  end

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Bench for vec_alu_pipe: directed scenarios plus random
// traffic against a queue-based arithmetic reference model.
module tb_vec_alu_pipe;

  localparam int L  = 6;
  localparam int W  = 8;
  localparam int IW = 3;
  localparam int VW = L * W;

  typedef struct packed {
    logic [VW-1:0]  r;
    logic [2*L-1:0] f;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [VW-1:0]  src_a = '0;
  logic [VW-1:0]  src_b = '0;
  logic [IW-1:0]  b_idx = '0;
  logic [W-1:0]   imm = '0;
  logic [1:0]     b_sel = '0;
  logic [2:0]     alu_ctrl = '0;
  logic [L-1:0]   lane_mask = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [VW-1:0]  result;
  logic [2*L-1:0] flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_alu_pipe #(.LANES(L), .WIDTH(W), .IDXW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b),
    .b_idx(b_idx), .imm(imm), .b_sel(b_sel),
    .alu_ctrl(alu_ctrl), .lane_mask(lane_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  // Reference: plain integer arithmetic per lane, merged onto prior state.
  function automatic exp_t model(
    input logic [2:0] op, input logic [1:0] bsel,
    input logic [IW-1:0] idx, input logic [W-1:0] im,
    input logic [VW-1:0] a, input logic [VW-1:0] b,
    input logic [L-1:0] m, input exp_t prev);
    exp_t e;
    int av, bv, rv, cv, sh, p, bi;
    e = prev;
    bi = (int'(idx) < L) ? int'(idx) : 0;
    for (int i = 0; i < L; i++) begin
      av = int'(a[i*W +: W]);
      case (bsel)
        2'd1:    bv = int'(b[bi*W +: W]);
        2'd2:    bv = int'(im);
        default: bv = int'(b[i*W +: W]);
      endcase
      cv = 0;
      case (op)
        3'd0: begin rv = av + bv; cv = rv >> W; rv = rv % (1 << W); end
        3'd1: begin cv = (av >= bv) ? 1 : 0; rv = (av - bv + (1 << W)) % (1 << W); end
        3'd2: rv = av & bv;
        3'd3: rv = av | bv;
        3'd4: rv = av ^ bv;
        3'd5: begin
          sh = bv % W; rv = (av << sh) % (1 << W);
          cv = (sh == 0) ? 0 : (av >> (W - sh)) % 2;
        end
        3'd6: begin
          sh = bv % W; rv = av >> sh;
          cv = (sh == 0) ? 0 : (av >> (sh - 1)) % 2;
        end
        default: begin
          p = av * bv; rv = p % (1 << W);
          cv = (p >= (1 << W)) ? 1 : 0;
        end
      endcase
      if (m[i]) begin
        e.r[i*W +: W] = rv[W-1:0];
        e.f[2*i +: 2] = {rv == 0, cv[0]};
      end
    end
    return e;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic v, input logic [2:0] op, input logic [1:0] bs,
    input logic [VW-1:0] a, input logic [VW-1:0] b,
    input logic [IW-1:0] idx, input logic [W-1:0] im,
    input logic [L-1:0] m);
    in_valid = v; alu_ctrl = op; b_sel = bs;
    src_a = a; src_b = b; b_idx = idx; imm = im; lane_mask = m;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    tests++; if (result !== '0) begin fails++; $display("FAIL rst_result: got %h want 0", result); end
    tests++; if (flags !== '0) begin fails++; $display("FAIL rst_flags: got %h want 0", flags); end
    step();
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_add();
    logic [VW-1:0] a, b, want;
    do_reset();
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = W'(i + 1);
      b[i*W +: W] = 8'h10;
      want[i*W +: W] = W'(8'h11 + i);
    end
    drive(1'b1, 3'd0, 2'b00, a, b, '0, '0, '1);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_latency: out_valid got %b want 0", out_valid); end
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b want 1", out_valid); end
    tests++; if (result !== want) begin fails++; $display("FAIL add_result: got %h want %h", result, want); end
    tests++; if (flags !== '0) begin fails++; $display("FAIL add_flags: got %h want 0", flags); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drop: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sub_bcast();
    logic [VW-1:0] a, b;
    exp_t e;
    do_reset();
    a = {8'h05, 8'h01, 8'h20, 8'h0A, 8'h04, 8'h05};
    b = rnd_vec();
    b[2*W +: W] = 8'h05;
    drive(1'b1, 3'd1, 2'b01, a, b, 3'd2, W'($urandom), '1);
    e = model(3'd1, 2'b01, 3'd2, imm, a, b, '1, '0);
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sub_valid: got %b want 1", out_valid); end
    tests++; if ({flags[5:0], result[23:0]} !== {2'b01, 2'b00, 2'b11, 24'h05FF00}) begin
      fails++; $display("FAIL sub_lanes012: got %h/%h want 05ff00/01_00_11", result[23:0], flags[5:0]);
    end
    tests++; if ({result, flags} !== {e.r, e.f}) begin
      fails++; $display("FAIL sub_all: got %h/%h want %h/%h", result, flags, e.r, e.f);
    end
  endtask

  task automatic test_mask();
    logic [VW-1:0] a1, a2;
    exp_t e1, e2;
    do_reset();
    a1 = rnd_vec(); a2 = rnd_vec();
    e1 = model(3'd0, 2'b10, '0, 8'h01, a1, '0, 6'b111111, '0);
    e2 = model(3'd4, 2'b10, '0, 8'hFF, a2, '0, 6'b000101, e1);
    drive(1'b1, 3'd0, 2'b10, a1, '0, '0, 8'h01, 6'b111111);
    step();
    drive(1'b1, 3'd4, 2'b10, a2, '0, '0, 8'hFF, 6'b000101);
    step();
    in_valid = 1'b0;
    tests++; if ({result, flags} !== {e1.r, e1.f}) begin
      fails++; $display("FAIL mask_op1: got %h/%h want %h/%h", result, flags, e1.r, e1.f);
    end
    step();
    tests++; if ({result, flags} !== {e2.r, e2.f}) begin
      fails++; $display("FAIL mask_op2: got %h/%h want %h/%h", result, flags, e2.r, e2.f);
    end
    tests++; if ({result[47:24], result[15:8], flags[11:6], flags[3:2]} !==
                 {e1.r[47:24], e1.r[15:8], e1.f[11:6], e1.f[3:2]}) begin
      fails++; $display("FAIL mask_keep: got %h want %h", result, e1.r);
    end
    tests++; if ({result[23:16], result[7:0]} !== ~{a2[23:16], a2[7:0]}) begin
      fails++; $display("FAIL mask_write: got %h want %h", {result[23:16], result[7:0]}, ~{a2[23:16], a2[7:0]});
    end
    drive(1'b1, 3'd0, 2'b00, rnd_vec(), rnd_vec(), '0, '0, '0);
    step();
    in_valid = 1'b0;
    step();
    tests++; if ({out_valid, result, flags} !== {1'b1, e2.r, e2.f}) begin
      fails++; $display("FAIL mask_zero: got %b %h/%h want 1 %h/%h", out_valid, result, flags, e2.r, e2.f);
    end
  endtask

  task automatic test_shift_mul();
    do_reset();
    drive(1'b1, 3'd5, 2'b10, {L{8'h81}}, '0, '0, 8'h01, '1);
    step(); in_valid = 1'b0; step();
    tests++; if ({result, flags} !== {{L{8'h02}}, {L{2'b01}}}) begin
      fails++; $display("FAIL sll: got %h/%h want 02../01..", result, flags);
    end
    drive(1'b1, 3'd6, 2'b10, {L{8'h81}}, '0, '0, 8'h00, '1);
    step(); in_valid = 1'b0; step();
    tests++; if ({result, flags} !== {{L{8'h81}}, {L{2'b00}}}) begin
      fails++; $display("FAIL srl0: got %h/%h want 81../00..", result, flags);
    end
    drive(1'b1, 3'd7, 2'b10, {L{8'h10}}, '0, '0, 8'h10, '1);
    step(); in_valid = 1'b0; step();
    tests++; if ({result, flags} !== {{L{8'h00}}, {L{2'b11}}}) begin
      fails++; $display("FAIL mul: got %h/%h want 00../11..", result, flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] a1, b1, a2, b2, a3, b3;
    exp_t e1, e2, e3;
    do_reset();
    a1 = rnd_vec(); b1 = rnd_vec();
    a2 = rnd_vec(); b2 = rnd_vec();
    a3 = rnd_vec(); b3 = rnd_vec();
    e1 = model(3'd0, 2'b00, '0, '0, a1, b1, '1, '0);
    e2 = model(3'd1, 2'b00, '0, '0, a2, b2, '1, e1);
    e3 = model(3'd4, 2'b00, '0, '0, a3, b3, '1, e2);
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 2'b00, a1, b1, '0, '0, '1);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    step();
    drive(1'b1, 3'd1, 2'b00, a2, b2, '0, '0, '1);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready2: got %b want 1", in_ready); end
    step();
    drive(1'b1, 3'd4, 2'b00, a3, b3, '0, '0, '1);
    for (int k = 0; k < 3; k++) begin
      tests++; if ({in_ready, out_valid, result, flags} !== {2'b01, e1.r, e1.f}) begin
        fails++; $display("FAIL bp_stall%0d: got rdy=%b v=%b %h/%h want 0 1 %h/%h",
                          k, in_ready, out_valid, result, flags, e1.r, e1.f);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if ({out_valid, result, flags} !== {1'b1, e2.r, e2.f}) begin
      fails++; $display("FAIL bp_op2: got %b %h/%h want 1 %h/%h", out_valid, result, flags, e2.r, e2.f);
    end
    step();
    tests++; if ({out_valid, result, flags} !== {1'b1, e3.r, e3.f}) begin
      fails++; $display("FAIL bp_op3: got %b %h/%h want 1 %h/%h", out_valid, result, flags, e3.r, e3.f);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] a, b;
    exp_t e;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 2'b00, rnd_vec(), rnd_vec(), '0, '0, '1);
    step();
    drive(1'b1, 3'd3, 2'b00, rnd_vec(), rnd_vec(), '0, '0, '1);
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({out_valid, result, flags} !== '0) begin
      fails++; $display("FAIL midrst_clear: got %b %h/%h want 0 0/0", out_valid, result, flags);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_flush: got %b want 0", out_valid); end
    a = rnd_vec(); b = rnd_vec();
    e = model(3'd0, 2'b00, '0, '0, a, b, '1, '0);
    drive(1'b1, 3'd0, 2'b00, a, b, '0, '0, '1);
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_lat: got %b want 0", out_valid); end
    step();
    tests++; if ({out_valid, result, flags} !== {1'b1, e.r, e.f}) begin
      fails++; $display("FAIL midrst_op: got %b %h/%h want 1 %h/%h", out_valid, result, flags, e.r, e.f);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t st;
    exp_t got;
    logic rdy_exp;
    do_reset();
    st = '0;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, 3'($urandom), 2'($urandom),
            rnd_vec(), rnd_vec(), IW'($urandom), W'($urandom), L'($urandom));
      out_ready = ($urandom % 3) != 0;
      #1;
      rdy_exp = (q.size() < 2) || out_ready;
      tests++; if (in_ready !== rdy_exp) begin
        fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, rdy_exp);
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rnd_spurious c%0d: got out_valid=1 want none", c);
        end else begin
          got = q.pop_front();
          if ({result, flags} !== {got.r, got.f}) begin
            fails++; $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, result, flags, got.r, got.f);
          end
        end
      end
      if (in_valid && in_ready) begin
        st = model(alu_ctrl, b_sel, b_idx, imm, src_a, src_b, lane_mask, st);
        q.push_back(st);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      if (out_valid) begin
        tests++;
        got = q.pop_front();
        if ({result, flags} !== {got.r, got.f}) begin
          fails++; $display("FAIL rnd_drain: got %h/%h want %h/%h", result, flags, got.r, got.f);
        end
      end
      step();
    end
    tests++; if (q.size() != 0) begin
      fails++; $display("FAIL rnd_timeout: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_bcast();
    test_mask();
    test_shift_mul();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
